// File: rtl/message_stream_demux.sv
// ============================================================================
// Module   : message_stream_demux
// Purpose  : Splits a header+payload word stream into per-stream outputs that
//            share one data bus and are flagged by a one-hot valid.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module message_stream_demux #(
  parameter int N_STREAMS         = 2,
  parameter int ID_WIDTH          = 1,
  parameter int WDTH              = 32,
  parameter int MAX_PACKET_LENGTH = 127,
  parameter int MSG_LENGTH_WIDTH  = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WDTH-1:0]      in_data,
  input  logic                 in_nd,
  output logic [WDTH-1:0]      out_data,
  output logic [N_STREAMS-1:0] out_nd,
  output logic                 error
);

  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  localparam logic [N_STREAMS-1:0]        C_ONE_HOT_BASE = N_STREAMS'(1);
  localparam logic [MSG_LENGTH_WIDTH-1:0] C_LEN_ONE      = MSG_LENGTH_WIDTH'(1);

  state_t                      state_q;
  logic [MSG_LENGTH_WIDTH-1:0] count_q;
  logic [ID_WIDTH-1:0]         id_q;
  logic [WDTH-1:0]             out_data_q;
  logic [N_STREAMS-1:0]        out_nd_q;
  logic                        error_q;

  logic                        w_hdr_flag;
  logic [MSG_LENGTH_WIDTH-1:0] w_hdr_len;
  logic [ID_WIDTH-1:0]         w_hdr_id;
  logic                        w_len_bad;
  logic                        w_id_bad;

  assign w_hdr_flag = in_data[WDTH-1];
  assign w_hdr_len  = in_data[ID_WIDTH+MSG_LENGTH_WIDTH-1:ID_WIDTH];
  assign w_hdr_id   = in_data[ID_WIDTH-1:0];
  assign w_len_bad  = (32'(w_hdr_len) > 32'(MAX_PACKET_LENGTH));
  assign w_id_bad   = (32'(w_hdr_id) >= 32'(N_STREAMS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HEADER;
      count_q    <= '0;
      id_q       <= '0;
      out_data_q <= '0;
      out_nd_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      // Valid is a single-cycle strobe; only a payload beat re-asserts it.
      out_nd_q <= '0;
      if (in_nd) begin
        case (state_q)
          ST_HEADER: begin
            if (!w_hdr_flag) begin
              error_q <= 1'b1;
            end else if (w_hdr_len != '0) begin
              count_q <= w_hdr_len;
              if (w_len_bad || w_id_bad) begin
                // Swallow the declared length so framing survives a bad header.
                error_q <= 1'b1;
                state_q <= ST_DISCARD;
              end else begin
                id_q    <= w_hdr_id;
                state_q <= ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            out_data_q <= in_data;
            out_nd_q   <= C_ONE_HOT_BASE << id_q;
            count_q    <= count_q - C_LEN_ONE;
            if (count_q == C_LEN_ONE) begin
              state_q <= ST_HEADER;
            end
          end
          ST_DISCARD: begin
            count_q <= count_q - C_LEN_ONE;
            if (count_q == C_LEN_ONE) begin
              state_q <= ST_HEADER;
            end
          end
          default: begin
            state_q <= ST_HEADER;
          end
        endcase
      end
    end
  end

  assign out_data = out_data_q;
  assign out_nd   = out_nd_q;
  assign error    = error_q;

endmodule

`default_nettype wire

// File: tb/tb_message_stream_demux.sv
// ============================================================================
// Module   : tb_message_stream_demux
// Purpose  : Scoreboard bench for message_stream_demux (default and 2-bit-id
//            instances) using directed vectors.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_message_stream_demux;

  typedef struct {
    logic [1:0]  nd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] in_data_a, in_data_b;
  logic        in_nd_a, in_nd_b;
  logic [31:0] out_data_a, out_data_b;
  logic [1:0]  out_nd_a, out_nd_b;
  logic        error_a, error_b;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t qa[$];
  exp_t qb[$];

  message_stream_demux dut_a (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data_a),
    .in_nd    (in_nd_a),
    .out_data (out_data_a),
    .out_nd   (out_nd_a),
    .error    (error_a)
  );

  message_stream_demux #(
    .N_STREAMS         (2),
    .ID_WIDTH          (2),
    .WDTH              (32),
    .MAX_PACKET_LENGTH (3),
    .MSG_LENGTH_WIDTH  (7)
  ) dut_b (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data_b),
    .in_nd    (in_nd_b),
    .out_data (out_data_b),
    .out_nd   (out_nd_b),
    .error    (error_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: an entry due this cycle must match; any other strobe is spurious.
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0 && qa[0].cyc == cyc) begin
      e = qa.pop_front();
      chk("a_out_nd", 32'(out_nd_a), 32'(e.nd));
      chk("a_out_data", out_data_a, e.data);
    end else if (out_nd_a != 2'b00) begin
      chk("a_unexpected_nd", 32'(out_nd_a), 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (qb.size() > 0 && qb[0].cyc == cyc) begin
      e = qb.pop_front();
      chk("b_out_nd", 32'(out_nd_b), 32'(e.nd));
      chk("b_out_data", out_data_b, e.data);
    end else if (out_nd_b != 2'b00) begin
      chk("b_unexpected_nd", 32'(out_nd_b), 32'd0);
    end
  end

  task automatic send_a(input logic [31:0] w, input bit expect_out, input logic [1:0] nd);
    @(negedge clk);
    in_data_a = w;
    in_nd_a   = 1'b1;
    if (expect_out) qa.push_back('{nd, w, cyc + 1});
  endtask

  task automatic send_b(input logic [31:0] w, input bit expect_out, input logic [1:0] nd);
    @(negedge clk);
    in_data_b = w;
    in_nd_b   = 1'b1;
    if (expect_out) qb.push_back('{nd, w, cyc + 1});
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_nd_a   = 1'b0;
      in_data_a = 32'hDEAD_BEEF;
    end
  endtask

  task automatic idle_b(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_nd_b   = 1'b0;
      in_data_b = 32'hDEAD_BEEF;
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_data_a = '0;
    in_data_b = '0;
    in_nd_a   = 1'b0;
    in_nd_b   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a_nd", 32'(out_nd_a), 32'd0);
    chk("rst_a_data", out_data_a, 32'd0);
    chk("rst_a_err", 32'(error_a), 32'd0);
    chk("rst_b_nd", 32'(out_nd_b), 32'd0);
    chk("rst_b_data", out_data_b, 32'd0);
    chk("rst_b_err", 32'(error_b), 32'd0);
    reset = 1'b0;

    // Basic: id 1, L=3, back-to-back
    send_a(32'h8000_0007, 0, 2'b00);
    send_a(32'h0000_000A, 1, 2'b10);
    send_a(32'h0000_000B, 1, 2'b10);
    send_a(32'h0000_000C, 1, 2'b10);
    idle_a(2);
    chk("basic_err", 32'(error_a), 32'd0);
    chk("basic_hold", out_data_a, 32'h0000_000C);

    // Back-to-back packets on different streams
    send_a(32'h8000_0004, 0, 2'b00);
    send_a(32'h0000_0001, 1, 2'b01);
    send_a(32'h0000_0002, 1, 2'b01);
    send_a(32'h8000_0003, 0, 2'b00);
    send_a(32'h0000_0003, 1, 2'b10);
    idle_a(2);

    // Gaps between every word
    send_a(32'h8000_0007, 0, 2'b00); idle_a(1);
    send_a(32'h0000_000A, 1, 2'b10); idle_a(1);
    send_a(32'h0000_000B, 1, 2'b10); idle_a(1);
    send_a(32'h0000_000C, 1, 2'b10); idle_a(2);
    chk("gaps_err", 32'(error_a), 32'd0);

    // Empty packet, then orphan payload word in HEADER
    send_a(32'h8000_0000, 0, 2'b00); idle_a(1);
    chk("empty_err", 32'(error_a), 32'd0);
    send_a(32'h0000_0055, 0, 2'b00); idle_a(1);
    chk("orphan_err", 32'(error_a), 32'd1);
    send_a(32'h8000_0003, 0, 2'b00);
    send_a(32'h0000_0009, 1, 2'b10);
    idle_a(2);
    chk("orphan_sticky", 32'(error_a), 32'd1);

    // Bad id on the 2-bit-id instance, then recovery
    send_b(32'h8000_000A, 0, 2'b00);
    send_b(32'h0000_0005, 0, 2'b00);
    send_b(32'h0000_0006, 0, 2'b00);
    send_b(32'h8000_0005, 0, 2'b00);
    send_b(32'h0000_0007, 1, 2'b10);
    idle_b(2);
    chk("badid_err", 32'(error_b), 32'd1);

    // L == MAX (3) is legal; L == 4 exceeds MAX and is discarded in full
    send_b(32'h8000_000C, 0, 2'b00);
    send_b(32'h0000_0011, 1, 2'b01);
    send_b(32'h0000_0012, 1, 2'b01);
    send_b(32'h8000_0013, 1, 2'b01);
    send_b(32'h8000_0010, 0, 2'b00);
    send_b(32'h8000_0021, 0, 2'b00);
    send_b(32'h0000_0022, 0, 2'b00);
    send_b(32'h8000_0023, 0, 2'b00);
    send_b(32'h0000_0024, 0, 2'b00);
    send_b(32'h8000_0005, 0, 2'b00);
    send_b(32'h0000_000E, 1, 2'b10);
    idle_b(2);

    // Reset mid-packet: first payload beat is wiped by async reset
    send_a(32'h8000_0009, 0, 2'b00);
    send_a(32'h0000_0001, 0, 2'b00);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    in_nd_a = 1'b0;
    @(negedge clk);
    chk("midrst_nd", 32'(out_nd_a), 32'd0);
    chk("midrst_err", 32'(error_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send_a(32'h8000_0003, 0, 2'b00);
    send_a(32'h0000_0002, 1, 2'b10);
    idle_a(3);
    chk("midrst_err_after", 32'(error_a), 32'd0);

    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
